// File: rtl/crc32_rx_checker.sv
// Receive-side CRC-32 checker: recomputes CRC over each framed payload, strips the two trailing FCS words,
// forwards the payload with SOP/EOP, and reports per-frame pass/fail with saturating frame counters.
module crc32_rx_checker #(
  parameter logic FCS_INVERT = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [15:0]      rx_data,
  input  logic             rx_valid,
  input  logic             rx_sop,
  input  logic             rx_eop,
  output logic [15:0]      out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_crc_ok,
  output logic             out_err,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_bad_cnt
);

  localparam logic [31:0] POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H1   = 2'd1,
    H2   = 2'd2
  } state_t;

  // 16 message bits per call, rx_data[15] first, no reflection.
  function automatic logic [31:0] crc_next(input logic [31:0] crc_in, input logic [15:0] d);
    logic [31:0] c;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  state_t      state, state_n;
  logic [15:0] h0, h1;
  logic [31:0] crc;
  logic        first;

  logic        load_sop, shift, emit, last, err;
  logic [1:0]  bad_inc;
  logic [31:0] crc_upd, expected;
  logic        pass;

  assign crc_upd  = crc_next(crc, h1);
  assign expected = {h0, rx_data} ^ {32{FCS_INVERT}};
  assign pass     = (crc_upd == expected);

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    load_sop = 1'b0;
    shift    = 1'b0;
    emit     = 1'b0;
    last     = 1'b0;
    err      = 1'b0;
    bad_inc  = 2'd0;
    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_sop && rx_eop) begin
            err     = 1'b1;
            bad_inc = 2'd1;
          end else if (rx_sop) begin
            load_sop = 1'b1;
            state_n  = H1;
          end
        end
        H1, H2: begin
          if (rx_sop) begin
            // Early SOP aborts the open frame; with EOP the new word is also a runt.
            err = 1'b1;
            if (rx_eop) begin
              bad_inc = 2'd2;
              state_n = IDLE;
            end else begin
              bad_inc  = 2'd1;
              load_sop = 1'b1;
              state_n  = H1;
            end
          end else if (state == H1) begin
            if (rx_eop) begin
              err     = 1'b1;
              bad_inc = 2'd1;
              state_n = IDLE;
            end else begin
              shift   = 1'b1;
              state_n = H2;
            end
          end else begin
            emit  = 1'b1;
            shift = 1'b1;
            if (rx_eop) begin
              last    = 1'b1;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      h0            <= '0;
      h1            <= '0;
      crc           <= '0;
      first         <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_crc_ok    <= 1'b0;
      out_err       <= 1'b0;
      frame_ok_cnt  <= '0;
      frame_bad_cnt <= '0;
    end else begin
      out_valid  <= emit;
      out_sop    <= emit & first;
      out_eop    <= last;
      out_crc_ok <= last & pass;
      out_err    <= err;
      if (emit) begin
        out_data <= h1;
        crc      <= crc_upd;
        first    <= 1'b0;
      end
      if (load_sop) begin
        h0    <= rx_data;
        crc   <= CRC_INIT;
        first <= 1'b1;
      end
      if (shift) begin
        h1 <= h0;
        h0 <= rx_data;
      end
      frame_ok_cnt  <= sat_add(frame_ok_cnt, {1'b0, last & pass});
      frame_bad_cnt <= sat_add(frame_bad_cnt, bad_inc + {1'b0, last & ~pass});
    end
  end

endmodule

// File: tb/tb_crc32_rx_checker.sv
// Self-checking bench for crc32_rx_checker: directed frames plus randomized frames with gaps, checked against
// a polynomial long-division CRC model and a frame-level expectation queue.
module tb_crc32_rx_checker;

  typedef logic [7:0]  byteq_t[$];
  typedef logic [15:0] wordq_t[$];
  typedef logic [18:0] rec_t;  // {data, sop, eop, crc_ok}

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;

  logic [15:0] d0_data, d1_data, ds_data;
  logic        d0_valid, d0_sop, d0_eop, d0_ok, d0_err;
  logic        d1_valid, d1_sop, d1_eop, d1_ok, d1_err;
  logic        ds_valid, ds_sop, ds_eop, ds_ok, ds_err;
  logic [15:0] d0_okc, d0_badc, d1_okc, d1_badc;
  logic [2:0]  ds_okc, ds_badc;

  always #5 sys_clk = ~sys_clk;

  crc32_rx_checker #(.FCS_INVERT(1'b0), .CNT_W(16)) d0 (
    .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .out_data(d0_data), .out_valid(d0_valid), .out_sop(d0_sop), .out_eop(d0_eop), .out_crc_ok(d0_ok),
    .out_err(d0_err), .frame_ok_cnt(d0_okc), .frame_bad_cnt(d0_badc));

  crc32_rx_checker #(.FCS_INVERT(1'b1), .CNT_W(16)) d1 (
    .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .out_data(d1_data), .out_valid(d1_valid), .out_sop(d1_sop), .out_eop(d1_eop), .out_crc_ok(d1_ok),
    .out_err(d1_err), .frame_ok_cnt(d1_okc), .frame_bad_cnt(d1_badc));

  crc32_rx_checker #(.FCS_INVERT(1'b0), .CNT_W(3)) ds (
    .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .out_data(ds_data), .out_valid(ds_valid), .out_sop(ds_sop), .out_eop(ds_eop), .out_crc_ok(ds_ok),
    .out_err(ds_err), .frame_ok_cnt(ds_okc), .frame_bad_cnt(ds_badc));

  int   n_cmp = 0, n_mis = 0;
  rec_t got0_q[$], got1_q[$], gots_q[$], exp0_q[$], exp1_q[$];
  int   err0 = 0, err1 = 0, errs = 0, exp_err = 0;
  int   ok0 = 0, bad0 = 0, ok1 = 0, bad1 = 0, oks = 0, bads = 0;
  bit   gap_en = 1'b0;

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (d0_valid) got0_q.push_back({d0_data, d0_sop, d0_eop, d0_ok});
      if (d1_valid) got1_q.push_back({d1_data, d1_sop, d1_eop, d1_ok});
      if (ds_valid) gots_q.push_back({ds_data, ds_sop, ds_eop, ds_ok});
      if (d0_err) err0++;
      if (d1_err) err1++;
      if (ds_err) errs++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: remainder of (init * x^n + M(x) * x^32) mod P by explicit long division on a bit list.
  function automatic logic [31:0] crc_model(input byteq_t msg);
    bit          a[$];
    int          n;
    logic [32:0] p;
    logic [31:0] r;
    p = 33'h1_04C1_1DB7;
    foreach (msg[i]) for (int b = 7; b >= 0; b--) a.push_back(msg[i][b]);
    n = a.size();
    repeat (32) a.push_back(1'b0);
    for (int i = 0; i < 32; i++) a[i] = ~a[i];
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j <= 32; j++) a[i+j] = a[i+j] ^ p[32-j];
    for (int k = 0; k < 32; k++) r[31-k] = a[n+k];
    return r;
  endfunction

  function automatic byteq_t words_to_bytes(input wordq_t w);
    byteq_t b;
    foreach (w[i]) begin
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
    end
    return b;
  endfunction

  function automatic int sat3(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic idle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic put(input logic [15:0] d, input logic s, input logic e);
    if (gap_en) repeat ($urandom_range(0, 2)) idle();
    rx_data  = d;
    rx_sop   = s;
    rx_eop   = e;
    rx_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
  endtask

  task automatic bump_bad(input int n);
    bad0 += n;
    bad1 += n;
    bads += n;
    exp_err++;
  endtask

  task automatic expect_frame(input wordq_t pl, input logic [31:0] fcs);
    logic [31:0] c;
    bit          p0, p1, is_last;
    c  = crc_model(words_to_bytes(pl));
    p0 = (fcs == c);
    p1 = (fcs == ~c);
    foreach (pl[i]) begin
      is_last = (i == pl.size() - 1);
      exp0_q.push_back({pl[i], i == 0, is_last, is_last & p0});
      exp1_q.push_back({pl[i], i == 0, is_last, is_last & p1});
    end
    if (p0) begin ok0++; oks++; end else begin bad0++; bads++; end
    if (p1) ok1++; else bad1++;
  endtask

  task automatic send_frame(input wordq_t pl, input bit corrupt, input bit inv);
    logic [31:0] fcs;
    fcs = crc_model(words_to_bytes(pl));
    if (inv) fcs = ~fcs;
    if (corrupt) fcs[0] = ~fcs[0];
    foreach (pl[i]) put(pl[i], i == 0, 1'b0);
    put(fcs[31:16], 1'b0, 1'b0);
    put(fcs[15:0], 1'b0, 1'b1);
    expect_frame(pl, fcs);
  endtask

  task automatic compare_all(input string tag);
    int n;
    repeat (3) idle();
    chk({tag, ":n_out0"}, got0_q.size(), exp0_q.size());
    n = (got0_q.size() < exp0_q.size()) ? got0_q.size() : exp0_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s:rec0_%0d", tag, i), 32'(got0_q[i]), 32'(exp0_q[i]));
    chk({tag, ":n_outs"}, gots_q.size(), exp0_q.size());
    n = (gots_q.size() < exp0_q.size()) ? gots_q.size() : exp0_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s:recs_%0d", tag, i), 32'(gots_q[i]), 32'(exp0_q[i]));
    chk({tag, ":n_out1"}, got1_q.size(), exp1_q.size());
    n = (got1_q.size() < exp1_q.size()) ? got1_q.size() : exp1_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s:rec1_%0d", tag, i), 32'(got1_q[i]), 32'(exp1_q[i]));
    chk({tag, ":err0"}, err0, exp_err);
    chk({tag, ":err1"}, err1, exp_err);
    chk({tag, ":errs"}, errs, exp_err);
    chk({tag, ":ok0"}, d0_okc, ok0);
    chk({tag, ":bad0"}, d0_badc, bad0);
    chk({tag, ":ok1"}, d1_okc, ok1);
    chk({tag, ":bad1"}, d1_badc, bad1);
    chk({tag, ":oks"}, ds_okc, sat3(oks));
    chk({tag, ":bads"}, ds_badc, sat3(bads));
    got0_q.delete(); got1_q.delete(); gots_q.delete(); exp0_q.delete(); exp1_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    got0_q.delete(); got1_q.delete(); gots_q.delete(); exp0_q.delete(); exp1_q.delete();
    err0 = 0; err1 = 0; errs = 0; exp_err = 0;
    ok0 = 0; bad0 = 0; ok1 = 0; bad1 = 0; oks = 0; bads = 0;
  endtask

  initial begin
    byteq_t      check_str;
    wordq_t      pl;
    logic [31:0] fcs;

    repeat (3) idle();
    rst = 1'b0;
    chk("rst_valid", d0_valid, 1'b0);
    chk("rst_data", d0_data, 16'h0);
    chk("rst_ok_cnt", d0_okc, 16'h0);
    chk("rst_bad_cnt", d0_badc, 16'h0);

    check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_check", crc_model(check_str), 32'h0376_E6E7);

    // Good frame with latency checks.
    pl  = '{16'h1234, 16'hABCD, 16'h0F0F};
    fcs = crc_model(words_to_bytes(pl));
    put(16'h1234, 1'b1, 1'b0);
    put(16'hABCD, 1'b0, 1'b0);
    chk("lat_before", d0_valid, 1'b0);
    put(16'h0F0F, 1'b0, 1'b0);
    chk("lat_valid", d0_valid, 1'b1);
    chk("lat_data", d0_data, 16'h1234);
    chk("lat_sop", d0_sop, 1'b1);
    put(fcs[31:16], 1'b0, 1'b0);
    put(fcs[15:0], 1'b0, 1'b1);
    chk("last_eop", d0_eop, 1'b1);
    chk("last_ok", d0_ok, 1'b1);
    chk("last_data", d0_data, 16'h0F0F);
    expect_frame(pl, fcs);
    compare_all("good");

    send_frame(pl, 1'b1, 1'b0);
    compare_all("corrupt");
    send_frame(pl, 1'b0, 1'b1);
    compare_all("invert");

    // Runts, then the shortest legal frame.
    put(16'h0101, 1'b1, 1'b1);
    bump_bad(1);
    put(16'h0202, 1'b1, 1'b0);
    put(16'h0303, 1'b0, 1'b1);
    bump_bad(1);
    send_frame('{16'h4242}, 1'b0, 1'b0);
    compare_all("runt");

    // Abort after one payload word was already emitted; new frame then passes.
    put(16'h1111, 1'b1, 1'b0);
    put(16'h2222, 1'b0, 1'b0);
    put(16'h3333, 1'b0, 1'b0);
    exp0_q.push_back({16'h1111, 1'b1, 1'b0, 1'b0});
    exp1_q.push_back({16'h1111, 1'b1, 1'b0, 1'b0});
    bump_bad(1);
    send_frame('{16'hAAAA, 16'hBBBB}, 1'b0, 1'b0);
    compare_all("abort");

    // SOP+EOP while a frame is open: abort plus runt, one error pulse.
    put(16'h5555, 1'b1, 1'b0);
    put(16'h6666, 1'b0, 1'b0);
    put(16'h7777, 1'b1, 1'b1);
    bump_bad(2);
    compare_all("abort_runt");

    // Random frames with random gaps.
    gap_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      wordq_t rp;
      int     len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) rp.push_back(16'($urandom));
      send_frame(rp, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    gap_en = 1'b0;
    compare_all("random");

    // Reset mid-frame discards the partial frame silently.
    put(16'h1111, 1'b1, 1'b0);
    put(16'h2222, 1'b0, 1'b0);
    do_reset();
    chk("mid_rst_data", d0_data, 16'h0);
    chk("mid_rst_ok", d0_okc, 16'h0);
    chk("mid_rst_bad", d0_badc, 16'h0);
    chk("mid_rst_bads", ds_badc, 3'd0);
    send_frame('{16'hC0DE, 16'hBEEF}, 1'b0, 1'b0);
    compare_all("after_rst");

    // Saturation of the narrow counters.
    for (int f = 0; f < 9; f++) send_frame('{16'(f), 16'h5A5A}, 1'b1, 1'b0);
    for (int f = 0; f < 9; f++) send_frame('{16'(f), 16'hA5A5}, 1'b0, 1'b0);
    compare_all("saturate");
    chk("sat_ok_hold", ds_okc, 3'd7);
    chk("sat_bad_hold", ds_badc, 3'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
